// File: rtl/quad_decoder_if.sv
// rtl/quad_decoder_if.sv - encoder inputs, control strobes and decoded outputs of quad_decoder
interface quad_decoder_if #(
    parameter int WIDTH = 4
);
    logic             enc_a;
    logic             enc_b;
    logic             clr;
    logic             err_clr;
    logic             step;
    logic             dir;
    logic [WIDTH-1:0] position;
    logic             err;

    modport master (
        output enc_a, enc_b, clr, err_clr,
        input  step, dir, position, err
    );

    modport slave (
        input  enc_a, enc_b, clr, err_clr,
        output step, dir, position, err
    );
endinterface

// File: rtl/quad_decoder.sv
// rtl/quad_decoder.sv - synchronized, debounced quadrature decoder with wrapping position count
module quad_decoder #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic          clk,
    input  logic          rst,
    quad_decoder_if.slave bus
);
    localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);
    localparam logic [WIDTH-1:0] POS_ONE  = WIDTH'(1);

    logic [SYNC_STAGES-1:0] sync_a;
    logic [SYNC_STAGES-1:0] sync_b;
    logic [1:0]             s_ab;
    logic [1:0]             f_ab;
    logic [CNT_W-1:0]       cnt [2];
    logic [1:0]             prev;

    logic [1:0]             diff;
    logic                   valid;
    logic                   illegal;
    logic                   up_mv;

    logic                   step_q;
    logic                   dir_q;
    logic [WIDTH-1:0]       pos_q;
    logic                   err_q;

    // Gray-code successor in the up direction: 00 -> 01 -> 11 -> 10 -> 00.
    function automatic logic [1:0] next_up(input logic [1:0] st);
        logic [1:0] nx;
        nx = 2'b00;
        case (st)
            2'b00: nx = 2'b01;
            2'b01: nx = 2'b11;
            2'b11: nx = 2'b10;
            2'b10: nx = 2'b00;
            default: nx = 2'b00;
        endcase
        return nx;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= {sync_a[SYNC_STAGES-2:0], bus.enc_a};
            sync_b <= {sync_b[SYNC_STAGES-2:0], bus.enc_b};
        end
    end

    assign s_ab = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};

    // Index 1 is channel A, index 0 is channel B, matching the {A,B} decode order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_ab <= 2'b00;
            for (int i = 0; i < 2; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (s_ab[i] == f_ab[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    f_ab[i] <= s_ab[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        diff    = prev ^ f_ab;
        valid   = ^diff;
        illegal = &diff;
        up_mv   = (f_ab == next_up(prev));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev   <= 2'b00;
            step_q <= 1'b0;
            dir_q  <= 1'b1;
            pos_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            prev   <= f_ab;
            step_q <= valid;
            if (valid) dir_q <= up_mv;

            // clr overrides the count but step/dir still report this cycle's move.
            if (bus.clr)
                pos_q <= '0;
            else if (valid)
                pos_q <= up_mv ? pos_q + POS_ONE : pos_q - POS_ONE;

            if (illegal)
                err_q <= 1'b1;
            else if (bus.err_clr)
                err_q <= 1'b0;
        end
    end

    assign bus.step     = step_q;
    assign bus.dir      = dir_q;
    assign bus.position = pos_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_quad_decoder.sv
// tb/tb_quad_decoder.sv - directed self-checking bench for quad_decoder
module tb_quad_decoder;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    quad_decoder_if #(.WIDTH(4)) bus ();

    quad_decoder #(
        .WIDTH(4),
        .SYNC_STAGES(2),
        .FILTER_LEN(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives A/B at a negedge and watches n following negedges for step pulses.
    task automatic drive(input logic a, input logic b, input int n,
                         output int steps, output int first);
        bus.enc_a = a;
        bus.enc_b = b;
        steps = 0;
        first = -1;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (bus.step === 1'b1) begin
                steps++;
                if (first < 0) first = i;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.enc_a = 1'b0;
        bus.enc_b = 1'b0;
        bus.clr = 1'b0;
        bus.err_clr = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.step, bus.dir, bus.err} !== 3'b010) begin
            failures++;
            $display("FAIL reset_flags: got step/dir/err=%b required 010", {bus.step, bus.dir, bus.err});
        end
        checks++;
        if (bus.position !== 4'd0) begin
            failures++;
            $display("FAIL reset_position: got %0d required 0", bus.position);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_up();
        logic [1:0] seq [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
        int st, fi;
        for (int k = 0; k < 4; k++) begin
            drive(seq[k][1], seq[k][0], 10, st, fi);
            if (k == 0) begin
                checks++;
                if (fi !== 7) begin
                    failures++;
                    $display("FAIL up_latency: got %0d edges required 7", fi);
                end
            end
            checks++;
            if (st !== 1 || bus.dir !== 1'b1 || bus.position !== 4'(k + 1)) begin
                failures++;
                $display("FAIL up_step%0d: got steps=%0d dir=%b pos=%0d required steps=1 dir=1 pos=%0d",
                         k, st, bus.dir, bus.position, k + 1);
            end
        end
    endtask

    task automatic test_down_wrap();
        logic [1:0] seq [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
        logic [3:0] exp_pos [4] = '{4'd15, 4'd14, 4'd13, 4'd12};
        int st, fi;
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
        checks++;
        if (bus.position !== 4'd0) begin
            failures++;
            $display("FAIL down_clr: got %0d required 0", bus.position);
        end
        for (int k = 0; k < 4; k++) begin
            drive(seq[k][1], seq[k][0], 10, st, fi);
            checks++;
            if (st !== 1 || bus.dir !== 1'b0 || bus.position !== exp_pos[k]) begin
                failures++;
                $display("FAIL down_step%0d: got steps=%0d dir=%b pos=%0d required steps=1 dir=0 pos=%0d",
                         k, st, bus.dir, bus.position, exp_pos[k]);
            end
        end
    endtask

    task automatic test_glitch();
        int st1, st2, fi;
        drive(1'b1, 1'b0, 3, st1, fi);
        drive(1'b0, 1'b0, 10, st2, fi);
        checks++;
        if (st1 + st2 !== 0 || bus.position !== 4'd12) begin
            failures++;
            $display("FAIL glitch_short: got steps=%0d pos=%0d required steps=0 pos=12", st1 + st2, bus.position);
        end
        // A alone rising from 00 gives {A,B}=10, which is the down direction.
        drive(1'b1, 1'b0, 10, st1, fi);
        checks++;
        if (st1 !== 1 || bus.dir !== 1'b0 || bus.position !== 4'd11) begin
            failures++;
            $display("FAIL glitch_held: got steps=%0d dir=%b pos=%0d required steps=1 dir=0 pos=11",
                     st1, bus.dir, bus.position);
        end
        drive(1'b0, 1'b0, 10, st1, fi);
        checks++;
        if (st1 !== 1 || bus.dir !== 1'b1 || bus.position !== 4'd12) begin
            failures++;
            $display("FAIL glitch_return: got steps=%0d dir=%b pos=%0d required steps=1 dir=1 pos=12",
                     st1, bus.dir, bus.position);
        end
    endtask

    task automatic test_illegal();
        int st, fi;
        drive(1'b1, 1'b1, 10, st, fi);
        checks++;
        if (st !== 0 || bus.err !== 1'b1 || bus.position !== 4'd12 || bus.dir !== 1'b1) begin
            failures++;
            $display("FAIL illegal_set: got steps=%0d err=%b pos=%0d dir=%b required steps=0 err=1 pos=12 dir=1",
                     st, bus.err, bus.position, bus.dir);
        end
        drive(1'b0, 1'b0, 6, st, fi);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        checks++;
        if (bus.err !== 1'b1 || bus.step !== 1'b0 || st !== 0) begin
            failures++;
            $display("FAIL illegal_set_wins: got err=%b step=%b steps=%0d required err=1 step=0 steps=0",
                     bus.err, bus.step, st);
        end
        repeat (3) @(negedge clk);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        checks++;
        if (bus.err !== 1'b0 || bus.position !== 4'd12) begin
            failures++;
            $display("FAIL illegal_err_clr: got err=%b pos=%0d required err=0 pos=12", bus.err, bus.position);
        end
    endtask

    task automatic test_clr_collision();
        logic [1:0] seq [5] = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01};
        int st, fi;
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
        for (int k = 0; k < 5; k++) drive(seq[k][1], seq[k][0], 10, st, fi);
        checks++;
        if (bus.position !== 4'd5) begin
            failures++;
            $display("FAIL clr_setup: got pos=%0d required 5", bus.position);
        end
        drive(1'b1, 1'b1, 6, st, fi);
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
        checks++;
        if (bus.step !== 1'b1 || bus.dir !== 1'b1 || bus.position !== 4'd0) begin
            failures++;
            $display("FAIL clr_collision: got step=%b dir=%b pos=%0d required step=1 dir=1 pos=0",
                     bus.step, bus.dir, bus.position);
        end
        @(negedge clk);
        checks++;
        if (bus.step !== 1'b0 || bus.position !== 4'd0) begin
            failures++;
            $display("FAIL clr_after: got step=%b pos=%0d required step=0 pos=0", bus.step, bus.position);
        end
    endtask

    task automatic test_async_reset();
        logic [1:0] seq [10] = '{2'b10, 2'b00, 2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
        int st, fi;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 10; k++) drive(seq[k][1], seq[k][0], 10, st, fi);
        drive(1'b1, 1'b0, 10, st, fi);
        checks++;
        if (bus.position !== 4'd9 || bus.dir !== 1'b0) begin
            failures++;
            $display("FAIL rst_setup: got pos=%0d dir=%b required pos=9 dir=0", bus.position, bus.dir);
        end
        drive(1'b0, 1'b0, 4, st, fi);
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({bus.step, bus.dir, bus.err} !== 3'b010 || bus.position !== 4'd0) begin
            failures++;
            $display("FAIL rst_async: got step/dir/err=%b pos=%0d required 010 pos=0",
                     {bus.step, bus.dir, bus.err}, bus.position);
        end
        #1 rst = 1'b0;
        @(negedge clk);
        drive(1'b0, 1'b1, 10, st, fi);
        checks++;
        if (st !== 1 || bus.dir !== 1'b1 || bus.position !== 4'd1 || bus.err !== 1'b0) begin
            failures++;
            $display("FAIL rst_restart: got steps=%0d dir=%b pos=%0d err=%b required steps=1 dir=1 pos=1 err=0",
                     st, bus.dir, bus.position, bus.err);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_up();
        test_down_wrap();
        test_glitch();
        test_illegal();
        test_clr_collision();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
